// File: rtl/bcd2bin_converter_if.sv
// Handshake and data bundle between a BCD requester and the BCD-to-binary converter.
interface bcd2bin_converter_if #(parameter int DIGITS = 4);
  localparam int BW = 4 * DIGITS;

  logic          start;
  logic [BW-1:0] bcd_in;
  logic [BW-1:0] binary_out;
  logic          busy;
  logic          done;
  logic          error;

  modport master (output start, bcd_in, input binary_out, busy, done, error);
  modport slave  (input start, bcd_in, output binary_out, busy, done, error);
endinterface

// File: rtl/bcd2bin_converter.sv
// Packed-BCD to binary via reverse double-dabble: shift right, then subtract 3
// from every BCD nibble that reaches 8 or more.
module bcd2bin_converter #(
  parameter int DIGITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  bcd2bin_converter_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BW + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, ADJUST, FINISH} state_t;

  state_t          state, state_nxt;
  logic [2*BW-1:0] shreg;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   binary_q;
  logic            done_q;
  logic            error_q;
  logic            digits_ok;
  logic [BW-1:0]   bcd_adj;

  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (bus.bcd_in[4*i +: 4] > 4'd9) digits_ok = 1'b0;
  end

  // Nibbles adjust independently; a borrow must never cross a digit boundary.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    logic [3:0] nib;
    assign nib = shreg[BW + 4*g +: 4];
    assign bcd_adj[4*g +: 4] = (nib >= 4'd8) ? (nib - 4'd3) : nib;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start && digits_ok) state_nxt = SHIFT;
      SHIFT:   state_nxt = ADJUST;
      ADJUST:  state_nxt = (cnt == '0) ? FINISH : SHIFT;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg    <= '0;
      cnt      <= '0;
      binary_q <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (digits_ok) begin
              shreg   <= {bus.bcd_in, {BW{1'b0}}};
              cnt     <= CW'(BW);
              error_q <= 1'b0;
            end else begin
              // Rejected operand: report immediately, no conversion runs.
              error_q  <= 1'b1;
              binary_q <= '0;
              done_q   <= 1'b1;
            end
          end
        end
        SHIFT: begin
          shreg <= shreg >> 1;
          cnt   <= cnt - 1'b1;
        end
        ADJUST: shreg[2*BW-1:BW] <= bcd_adj;
        FINISH: begin
          binary_q <= shreg[BW-1:0];
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.binary_out = binary_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_bcd2bin_converter.sv
// Scoreboard bench for bcd2bin_converter: expected results queued at request, checked at done.
module tb_bcd2bin_converter;
  localparam int DIGITS = 4;
  localparam int BW     = 4 * DIGITS;
  localparam int LAT    = 2 * BW + 1;

  typedef struct {
    logic [BW-1:0] bin;
    logic          err;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   done_total;
  int   busy_total;
  int   checks;
  int   failures;
  exp_t sb_q[$];

  bcd2bin_converter_if #(.DIGITS(DIGITS)) bus ();

  bcd2bin_converter #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.done) done_total <= done_total + 1;
    if (bus.busy) busy_total <= busy_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request for one edge; acc is the cycle stamp of the accepting edge.
  task automatic request(input logic [BW-1:0] bcd, input logic [BW-1:0] bin,
                         input logic err, input bit push, output int acc);
    exp_t e;
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    e.bin = bin;
    e.err = err;
    if (push) sb_q.push_back(e);
    tick();
    acc = cyc;
    bus.start = 1'b0;
  endtask

  // Returns in the cycle where done is high, after scoring the result.
  task automatic wait_done(input string tag, input int acc, input int lat, output int dcyc);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    dcyc = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      chk({tag, "_done_timeout"}, 32'd0, 32'd1);
      return;
    end
    dcyc = cyc;
    chk({tag, "_latency"}, dcyc - acc, lat);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_bin"}, 32'(bus.binary_out), 32'(e.bin));
      chk({tag, "_err"}, 32'(bus.error), 32'(e.err));
    end
  endtask

  task automatic run(input string tag, input logic [BW-1:0] bcd, input logic [BW-1:0] bin);
    int acc, dcyc, b0, d0;
    b0 = busy_total;
    d0 = done_total;
    request(bcd, bin, 1'b0, 1'b1, acc);
    chk({tag, "_busy_up"}, 32'(bus.busy), 32'd1);
    bus.bcd_in = ~bcd;
    wait_done(tag, acc, LAT, dcyc);
    tick();
    chk({tag, "_done_width"}, 32'(bus.done), 32'd0);
    chk({tag, "_hold"}, 32'(bus.binary_out), 32'(bin));
    chk({tag, "_busy_cycles"}, busy_total - b0, LAT);
    chk({tag, "_done_count"}, done_total - d0, 32'd1);
  endtask

  initial begin
    int acc, dcyc, dcyc2, d0, b0;
    cyc = 0; done_total = 0; busy_total = 0; checks = 0; failures = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.bcd_in = '0;
    repeat (3) tick();
    chk("rst_bin",   32'(bus.binary_out), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    reset = 1'b0;
    tick();

    run("c1234", 16'h1234, 16'h04D2);
    run("c9999", 16'h9999, 16'h270F);
    run("c0000", 16'h0000, 16'h0000);

    // Invalid digit: immediate done with error, no busy.
    b0 = busy_total;
    request(16'h12A4, 16'h0000, 1'b1, 1'b1, acc);
    chk("inv_busy", 32'(bus.busy), 32'd0);
    chk("inv_done", 32'(bus.done), 32'd1);
    chk("inv_error", 32'(bus.error), 32'd1);
    chk("inv_bin", 32'(bus.binary_out), 32'd0);
    void'(sb_q.pop_front());
    tick();
    chk("inv_done_width", 32'(bus.done), 32'd0);
    chk("inv_err_hold", 32'(bus.error), 32'd1);
    chk("inv_busy_cycles", busy_total - b0, 32'd0);
    request(16'h0042, 16'h002A, 1'b0, 1'b1, acc);
    chk("err_clear", 32'(bus.error), 32'd0);
    wait_done("c0042", acc, LAT, dcyc);

    // Start while busy is ignored.
    tick();
    d0 = done_total;
    request(16'h0500, 16'h01F4, 1'b0, 1'b1, acc);
    repeat (4) tick();
    bus.start = 1'b1;
    bus.bcd_in = 16'h0999;
    tick();
    bus.start = 1'b0;
    wait_done("c0500", acc, LAT, dcyc);
    repeat (40) tick();
    chk("ign_done_count", done_total - d0, 32'd1);
    chk("ign_hold", 32'(bus.binary_out), 32'h01F4);

    // Reset mid-conversion aborts without a done pulse.
    d0 = done_total;
    request(16'h0077, 16'h004D, 1'b0, 1'b0, acc);
    repeat (9) tick();
    @(posedge clk);
    reset = 1'b1;
    #1;
    chk("abort_bin", 32'(bus.binary_out), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_err", 32'(bus.error), 32'd0);
    tick();
    reset = 1'b0;
    repeat (40) tick();
    chk("abort_no_done", done_total - d0, 32'd0);
    run("c0010", 16'h0010, 16'h000A);

    // Back-to-back: re-request during the done cycle.
    request(16'h0001, 16'h0001, 1'b0, 1'b1, acc);
    wait_done("b2b1", acc, LAT, dcyc);
    request(16'h0002, 16'h0002, 1'b0, 1'b1, acc);
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    wait_done("b2b2", acc, LAT, dcyc2);
    chk("b2b_spacing", dcyc2 - dcyc, LAT + 1);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
